// File: rtl/gf2_mul_seq.sv
// Digit-serial carry-less multiplier over GF(2)[x] with optional reduction
// modulo x^WIDTH + POLY_LO; one operation in flight, valid/ready on both sides.
module gf2_mul_seq #(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      DIGIT   = 4,
  parameter logic [WIDTH-1:0] POLY_LO = WIDTH'(16'h002B)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 reduce,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-2:0]   y,
  output logic                 busy
);

  localparam int unsigned ACC_W = 2 * WIDTH - 1;
  localparam int unsigned NM    = WIDTH / DIGIT;
  localparam int unsigned NR    = (WIDTH - 1 + DIGIT - 1) / DIGIT;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] POLY_EXT = ACC_W'({1'b1, POLY_LO});

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("gf2_mul_seq: need WIDTH >= 2, 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               red_q;
  logic [ACC_W-1:0]   acc_q, acc_n;
  logic [CNT_W-1:0]   k_q, k_n;
  logic               capture;

  logic [DIGIT-1:0]   digit;
  logic [ACC_W-1:0]   pp;
  logic [ACC_W-1:0]   acc_mul;
  logic [ACC_W-1:0]   acc_red;
  int                 red_pos;

  // One MUL step: shift accumulator by a digit and add the digit's partial products.
  always_comb begin
    digit = DIGIT'((b_q << (int'(k_q) * int'(DIGIT))) >> (WIDTH - DIGIT));
    pp    = '0;
    for (int j = 0; j < int'(DIGIT); j++) begin
      if (digit[j]) pp = pp ^ (ACC_W'(a_q) << j);
    end
    acc_mul = (acc_q << DIGIT) ^ pp;
  end

  // One RED step: clear DIGIT top positions of the window, highest first, chained.
  always_comb begin
    acc_red = acc_q;
    red_pos = 0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      red_pos = int'(ACC_W - 1) - int'(k_q) * int'(DIGIT) - i;
      if ((red_pos >= int'(WIDTH)) && acc_red[IDX_W'(red_pos)]) begin
        acc_red = acc_red ^ (POLY_EXT << (red_pos - int'(WIDTH)));
      end
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    k_n     = k_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          acc_n   = '0;
          k_n     = '0;
          state_n = MUL;
        end
      end
      MUL: begin
        acc_n = acc_mul;
        if (k_q == CNT_W'(NM - 1)) begin
          k_n     = '0;
          state_n = red_q ? RED : DONE;
        end else begin
          k_n = CNT_W'(k_q + 1'b1);
        end
      end
      RED: begin
        acc_n = acc_red;
        if (k_q == CNT_W'(NR - 1)) begin
          k_n     = '0;
          state_n = DONE;
        end else begin
          k_n = CNT_W'(k_q + 1'b1);
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      red_q     <= 1'b0;
      acc_q     <= '0;
      k_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      k_q       <= k_n;
      if (capture) begin
        a_q   <= a;
        b_q   <= b;
        red_q <= reduce;
      end
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  assign y = acc_q;

endmodule

// File: tb/tb_gf2_mul_seq.sv
// Scoreboard bench for gf2_mul_seq: four WIDTH=16 digit variants plus an
// 8-bit AES-field variant, directed cases then a randomised run.
module tb_gf2_mul_seq;

  localparam int unsigned NV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_v  [NV];
  logic        in_ready_v  [NV];
  logic [15:0] a_v         [NV];
  logic [15:0] b_v         [NV];
  logic        reduce_v    [NV];
  logic        out_valid_v [NV];
  logic        out_ready_v [NV];
  logic [30:0] y_v         [NV];
  logic        busy_v      [NV];

  for (genvar g = 0; g < NV; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    gf2_mul_seq #(.WIDTH(16), .DIGIT(D), .POLY_LO(16'h002B)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .a(a_v[g]), .b(b_v[g]), .reduce(reduce_v[g]), .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]), .y(y_v[g]), .busy(busy_v[g])
    );
  end

  logic        in_valid8, in_ready8, reduce8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [14:0] y8;

  gf2_mul_seq #(.WIDTH(8), .DIGIT(8), .POLY_LO(8'h1B)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .reduce(reduce8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .busy(busy8)
  );

  logic [30:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int dig_of(int v);
    return (v == 0) ? 1 : (v == 1) ? 2 : (v == 2) ? 4 : 16;
  endfunction

  function automatic int lat_of(int v, logic red);
    int d = dig_of(v);
    return red ? (16 / d + (15 + d - 1) / d) : (16 / d);
  endfunction

  // Plain bit-at-a-time carry-less product, then long division by the modulus.
  function automatic logic [30:0] ref_mul(logic [15:0] x, logic [15:0] z, logic red);
    logic [30:0] r = '0;
    for (int i = 0; i < 16; i++) if (z[i]) r = r ^ (31'(x) << i);
    if (red) begin
      for (int p = 30; p >= 16; p--) if (r[p]) r = r ^ (31'({1'b1, 16'h002B}) << (p - 16));
    end
    return r;
  endfunction

  task automatic drive_req(int v, logic [15:0] x, logic [15:0] z, logic red, logic [30:0] exp);
    @(negedge clk);
    a_v[v] = x; b_v[v] = z; reduce_v[v] = red; in_valid_v[v] = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    in_valid_v[v] = 1'b0;
  endtask

  task automatic wait_valid(int v, output int lat);
    lat = 0;
    while (!out_valid_v[v] && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!out_valid_v[v]) lat = -1;
  endtask

  task automatic handshake(int v);
    out_ready_v[v] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_v[v] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int v = 0; v < NV; v++) begin
      in_valid_v[v] = 1'b0; a_v[v] = '0; b_v[v] = '0; reduce_v[v] = 1'b0; out_ready_v[v] = 1'b0;
    end
    in_valid8 = 1'b0; a8 = '0; b8 = '0; reduce8 = 1'b0; out_ready8 = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_v[2], out_valid_v[2], busy_v[2]} !== 3'b100) $display("FAIL reset_flags: got %b want 100", {in_ready_v[2], out_valid_v[2], busy_v[2]});
    else n_pass++;
    n_checks++;
    if (y_v[2] !== 31'h0) $display("FAIL reset_y: got %h want 0", y_v[2]);
    else n_pass++;
    n_checks++;
    if ({in_ready8, out_valid8, busy8, y8} !== {3'b100, 15'h0}) $display("FAIL reset_w8: got %h want %h", {in_ready8, out_valid8, busy8, y8}, {3'b100, 15'h0});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw();
    logic [15:0] ta [2] = '{16'h0003, 16'hFFFF};
    logic [30:0] te [2] = '{31'h00000005, 31'h55555555};
    int lat;
    logic [30:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive_req(2, ta[i], ta[i], 1'b0, te[i]);
      wait_valid(2, lat);
      n_checks++;
      if (lat !== 4) $display("FAIL raw_latency[%0d]: got %0d want 4", i, lat);
      else n_pass++;
      exp = sb.pop_front();
      n_checks++;
      if (y_v[2] !== exp) $display("FAIL raw_y[%0d]: got %h want %h", i, y_v[2], exp);
      else n_pass++;
      handshake(2);
      n_checks++;
      if ({out_valid_v[2], in_ready_v[2]} !== 2'b01) $display("FAIL raw_release[%0d]: got %b want 01", i, {out_valid_v[2], in_ready_v[2]});
      else n_pass++;
    end
  endtask

  task automatic test_reduce();
    logic [15:0] ta [2] = '{16'h8000, 16'h0000};
    logic [15:0] tb [2] = '{16'h0002, 16'h1234};
    logic [30:0] te [2] = '{31'h0000002B, 31'h0};
    int lat;
    logic [30:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive_req(2, ta[i], tb[i], 1'b1, te[i]);
      wait_valid(2, lat);
      n_checks++;
      if (lat !== 8) $display("FAIL red_latency[%0d]: got %0d want 8", i, lat);
      else n_pass++;
      exp = sb.pop_front();
      n_checks++;
      if (y_v[2] !== exp) $display("FAIL red_y[%0d]: got %h want %h", i, y_v[2], exp);
      else n_pass++;
      handshake(2);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [30:0] exp;
    drive_req(2, 16'hA5A5, 16'h0F0F, 1'b1, ref_mul(16'hA5A5, 16'h0F0F, 1'b1));
    wait_valid(2, lat);
    n_checks++;
    if (lat !== 8) $display("FAIL bp_latency: got %0d want 8", lat);
    else n_pass++;
    exp = sb.pop_front();
    for (int c = 0; c < 6; c++) begin
      in_valid_v[2] = (c % 2 == 0);
      a_v[2] = 16'($urandom); b_v[2] = 16'($urandom); reduce_v[2] = 1'($urandom);
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (y_v[2] !== exp) $display("FAIL bp_hold_y[%0d]: got %h want %h", c, y_v[2], exp);
      else n_pass++;
      n_checks++;
      if ({in_ready_v[2], out_valid_v[2], busy_v[2]} !== 3'b011) $display("FAIL bp_hold_flags[%0d]: got %b want 011", c, {in_ready_v[2], out_valid_v[2], busy_v[2]});
      else n_pass++;
    end
    // Request held high across the handshake edge must wait for IDLE.
    in_valid_v[2] = 1'b1; a_v[2] = 16'h0003; b_v[2] = 16'h0005; reduce_v[2] = 1'b0;
    out_ready_v[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_v[2] = 1'b0;
    n_checks++;
    if ({in_ready_v[2], out_valid_v[2], busy_v[2]} !== 3'b100) $display("FAIL bp_after_hs: got %b want 100", {in_ready_v[2], out_valid_v[2], busy_v[2]});
    else n_pass++;
    @(posedge clk);
    sb.push_back(31'h0000000F);
    @(negedge clk);
    in_valid_v[2] = 1'b0;
    wait_valid(2, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL bp_next_latency: got %0d want 4", lat);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if (y_v[2] !== exp) $display("FAIL bp_next_y: got %h want %h", y_v[2], exp);
    else n_pass++;
    handshake(2);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [30:0] exp;
    drive_req(2, 16'h1234, 16'h5678, 1'b1, 31'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready_v[2], out_valid_v[2], busy_v[2]} !== 3'b100) $display("FAIL midrst_flags: got %b want 100", {in_ready_v[2], out_valid_v[2], busy_v[2]});
    else n_pass++;
    n_checks++;
    if (y_v[2] !== 31'h0) $display("FAIL midrst_y: got %h want 0", y_v[2]);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_req(2, 16'h0003, 16'h0005, 1'b0, 31'h0000000F);
    wait_valid(2, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if (y_v[2] !== exp) $display("FAIL midrst_y_after: got %h want %h", y_v[2], exp);
    else n_pass++;
    handshake(2);
  endtask

  task automatic test_param_w8();
    logic       tr [2] = '{1'b1, 1'b0};
    logic [14:0] te [2] = '{15'h00C1, 15'h2B79};
    int tl [2] = '{2, 1};
    int lat;
    logic [30:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a8 = 8'h57; b8 = 8'h83; reduce8 = tr[i]; in_valid8 = 1'b1;
      @(posedge clk);
      sb.push_back(31'(te[i]));
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 200) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      if (!out_valid8) lat = -1;
      n_checks++;
      if (lat !== tl[i]) $display("FAIL w8_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      else n_pass++;
      exp = sb.pop_front();
      n_checks++;
      if (31'(y8) !== exp) $display("FAIL w8_y[%0d]: got %h want %h", i, y8, exp);
      else n_pass++;
      out_ready8 = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready8 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int v, lat, hold;
    logic [15:0] x, z;
    logic red, pre;
    logic [30:0] exp;
    for (int i = 0; i < 1000; i++) begin
      v    = int'($urandom_range(0, NV - 1));
      x    = 16'($urandom); z = 16'($urandom);
      red  = 1'($urandom); pre = 1'($urandom);
      hold = int'($urandom_range(0, 2));
      out_ready_v[v] = pre;
      drive_req(v, x, z, red, ref_mul(x, z, red));
      wait_valid(v, lat);
      n_checks++;
      if (lat !== lat_of(v, red)) $display("FAIL rnd_latency[%0d] v%0d: got %0d want %0d", i, v, lat, lat_of(v, red));
      else n_pass++;
      exp = sb.pop_front();
      n_checks++;
      if (y_v[v] !== exp) $display("FAIL rnd_y[%0d] v%0d: got %h want %h", i, v, y_v[v], exp);
      else n_pass++;
      if (pre) begin
        @(posedge clk); @(negedge clk);
        out_ready_v[v] = 1'b0;
      end else begin
        repeat (hold) begin @(posedge clk); @(negedge clk); end
        handshake(v);
      end
      n_checks++;
      if ({out_valid_v[v], in_ready_v[v]} !== 2'b01) $display("FAIL rnd_release[%0d] v%0d: got %b want 01", i, v, {out_valid_v[v], in_ready_v[v]});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_reduce();
    test_backpressure();
    test_reset_mid_op();
    test_param_w8();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf2_mul_seq.md
# gf2_mul_seq

Parametrised, digit-serial multiplier over GF(2)[x] (carry-less, XOR-only arithmetic) with an optional modular-reduction mode for GF(2^WIDTH) field multiplication. It trades the area of the fully combinational Karatsuba multipliers for WIDTH/DIGIT cycles of latency. It serves as the shared multiply engine behind a valid/ready request/response interface. One operation is in flight at a time.

## Interface
- WIDTH, 16, operand width in bits; ≥2.
- DIGIT, 4, bits of `b` consumed per MUL cycle; WIDTH % DIGIT == 0 and 1 ≤ DIGIT ≤ WIDTH, otherwise elaboration error.
- POLY_LO, 16'h002B, low WIDTH bits of the irreducible modulus; the x^WIDTH term is implicit. Default is x^16+x^5+x^3+x+1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- reduce  in  1  1 = return a·b mod (x^WIDTH + POLY_LO); 0 = raw product.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- y  out  2*WIDTH-1  result; in reduce mode bits [2*WIDTH-2:WIDTH] are 0.
- busy  out  1  state != IDLE.

## Operation
- States are IDLE, MUL, RED and DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and reduce; clear acc (2*WIDTH-1 bits) and digit counter k=0; go to MUL.
- **MUL:** runs for NM = WIDTH/DIGIT cycles. The cycle processes b digits MSB-first.
  - Let d be b bits [WIDTH-1-k*DIGIT -: DIGIT].
  - acc ← (acc << DIGIT) ^ XOR over j of (d[j] ? a<<j : 0).
  - Bits shifted beyond bit 2*WIDTH-2 are provably zero.
  - After the last digit: if reduce, go to RED; else go to DONE.
- **RED:** runs for NR = ceil((WIDTH-1)/DIGIT) cycles.
  - Cycle r handles positions p from 2*WIDTH-2-r*DIGIT downward for DIGIT positions, clipped at WIDTH.
  - Positions are processed in descending order within the cycle, with combinational dependency.
  - For each p: if acc[p], acc ← acc ^ (x^(p-WIDTH)·(x^WIDTH + POLY_LO)).
  - After the last window, acc[2*WIDTH-2:WIDTH]=0; go to DONE.
- **DONE:**
  - out_valid=1 and y=acc, both stable.
  - On out_ready: go to IDLE.
  - A new request can be accepted only the cycle after the DONE→IDLE transition; there is no overlap.
- in_valid during MUL, RED or DONE is ignored; in_ready=0 in those states.
- Operand registers are internal; a and b may change after acceptance without effect.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, acc=0, k=0.
- **Reset mid-operation:** rst at any point aborts immediately and asynchronously to the reset values. The result is discarded, with no partial out_valid.
- **Latency:** counted from the accepting edge to the first cycle with out_valid=1.
  - Raw: NM cycles.
  - Reduce: NM+NR cycles.
  - Defaults: raw 4, reduce 8.
  - WIDTH=8, DIGIT=8: raw 1, reduce 2.
- **Throughput:** at most one operation per NM(+NR)+2 cycles under out_ready=1.
- **Backpressure:** out_valid, y and busy are held indefinitely while out_ready=0.
- **Simultaneous events:**
  - out_ready high in the same cycle out_valid first rises: the result is consumed on that edge.
  - out_valid=0 and in_ready=1 from the next cycle.
- **Unused MSBs:** y upper bits in reduce mode are always 0 and are never left unknown.

## Test plan
- Raw, defaults. a=0x0003, b=0x0003, reduce=0 → y=0x00000005 at 4 cycles after accept; a=0xFFFF, b=0xFFFF → y=0x55555555.
- Reduce, defaults. a=0x8000, b=0x0002, reduce=1 → y=0x0000002B at 8 cycles; a=0x0000, b=0x1234 → y=0.
- Backpressure. Hold out_ready=0 for 6 cycles after out_valid rises, toggling in_valid with new operands throughout.
  - Required: y constant and in_ready=0 throughout.
  - Required: the held result is returned intact, and the next request is accepted only after the handshake.
- Reset mid-operation. Assert rst in the 2nd MUL cycle.
  - Required: in_ready=1, busy=0, out_valid=0 and y=0 immediately.
  - Required: a fresh request a=0x0003, b=0x0005 (raw) then returns y=0x0000000F.
- Parameter variant. WIDTH=8, DIGIT=8, POLY_LO=8'h1B, a=0x57, b=0x83, reduce=1 → y=0x00C1 at 2 cycles; the same operands raw → y=0x2B79.
- Randomised back-to-back run. 1000 random operands, both modes, DIGIT ∈ {1,2,4,16}, random out_ready.
  - Check against a bitwise carry-less reference model.
  - Check latency against the formula for every transaction.
